// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
// Also holds the elaboration-time helpers used to size the counter and validate parameters.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_NIBBLE  = 4;
    localparam int ADD3_THRESH = 5;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_ok(input int width, input int digits);
        longint p10;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        return p10 > ((longint'(1) << width) - 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the binary producer, the converter and the display consumer.
// The converter takes the slave view; the stimulus/consumer side takes the master view.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic [WIDTH-1:0]    bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   blank;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output bin_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  bcd_out,
        input  blank,
        input  out_valid
    );

    modport slave (
        input  bin_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output bcd_out,
        output blank,
        output out_valid
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the shift.
// Pure 4-bit arithmetic, no carry leaves the nibble.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_NIBBLE-1:0] digit,
    output logic [BCD_NIBBLE-1:0] fixed
);
    assign fixed = (digit >= BCD_NIBBLE'(ADD3_THRESH)) ? digit + BCD_NIBBLE'(3) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one add-3/shift step per clock, WIDTH steps per value.
// Result digits and a leading-zero blank mask are held stable until the next conversion ends.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input logic           CLK100MHZ,
    input logic           CPU_RESETN,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam int BW = BCD_NIBBLE * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    generate
        if (WIDTH < 4 || WIDTH > 27) begin : g_bad_width
            $fatal(1, "bin_to_bcd_seq: WIDTH %0d outside 4..27", WIDTH);
        end
        if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
            $fatal(1, "bin_to_bcd_seq: DIGITS %0d too small for WIDTH %0d", DIGITS, WIDTH);
        end
    endgenerate

    state_t              state_reg,   state_next;
    logic [WIDTH-1:0]    bin_reg,     bin_next;
    logic [BW-1:0]       scratch_reg, scratch_next;
    logic [CW-1:0]       cnt_reg,     cnt_next;
    logic [BW-1:0]       bcd_reg,     bcd_next;
    logic [DIGITS-1:0]   blank_reg,   blank_next;

    logic [BW-1:0]       scratch_fix;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       scratch_shift;
    logic [WIDTH-1:0]    bin_shift;
    logic [DIGITS-1:1]   zero_above;
    logic [DIGITS-1:0]   final_blank;
    logic                last_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit (scratch_reg[gi*BCD_NIBBLE +: BCD_NIBBLE]),
                .fixed (scratch_fix[gi*BCD_NIBBLE +: BCD_NIBBLE])
            );
        end
    endgenerate

    // The bit shifted out of the top is always zero because DIGITS is wide enough.
    assign shifted       = {scratch_fix, bin_reg} << 1;
    assign scratch_shift = shifted[BW+WIDTH-1:WIDTH];
    assign bin_shift     = shifted[WIDTH-1:0];
    assign last_shift    = (cnt_reg == CW'(WIDTH - 1));

    // zero_above[i] is set when digit i and every higher digit of the final scratch are zero.
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            if (gi == DIGITS - 1) begin : g_top
                assign zero_above[gi] = (scratch_shift[gi*BCD_NIBBLE +: BCD_NIBBLE] == '0);
            end else begin : g_mid
                assign zero_above[gi] = (scratch_shift[gi*BCD_NIBBLE +: BCD_NIBBLE] == '0)
                                        && zero_above[gi+1];
            end
        end
    endgenerate

    assign final_blank = {zero_above, 1'b0};

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            blank_reg   <= BLANK_RESET;
        end else begin
            state_reg   <= state_next;
            bin_reg     <= bin_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
            blank_reg   <= blank_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bin_next     = bin_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        bcd_next     = bcd_reg;
        blank_next   = blank_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    bin_next     = bus.bin_in;
                    scratch_next = '0;
                    cnt_next     = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                bin_next     = bin_shift;
                scratch_next = scratch_shift;
                cnt_next     = cnt_reg + 1'b1;
                if (last_shift) begin
                    bcd_next   = scratch_shift;
                    blank_next = final_blank;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.bcd_out   = bcd_reg;
    assign bus.blank     = blank_reg;

endmodule
